alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command front-end for the 8-bit bit-sliced ALU stack: drives operand bytes and
// selects, chains two byte passes for 16-bit work, and returns a registered response.
module alu_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic        cmd_wide,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        alu_cin,
   output logic        alu_bin,
   output logic [4:0]  alu_sel,
   input  logic [7:0]  alu_z,
   input  logic        alu_carry,
   input  logic        alu_overflow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_z,
   output logic        rsp_carry,
   output logic        rsp_overflow,
   output logic        rsp_zero,
   output logic        rsp_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_ADC = 3'd5;
   localparam logic [2:0] OP_SBB = 3'd6;
   localparam logic [2:0] OP_ILL = 3'd7;

   logic [1:0]  state;
   logic [2:0]  op_q;
   logic        wide_q;
   logic [7:0]  a_hi;
   logic [7:0]  b_hi;
   logic [15:0] res;
   logic        c_int;
   logic        v_int;
   logic        c_flag;

   logic        q_arith;
   logic        q_illegal;
   logic        res_zero;

   function automatic logic [4:0] sel_of(input logic [2:0] op);
      case (op)
         OP_ADD, OP_ADC: return 5'b00001;
         OP_SUB, OP_SBB: return 5'b00010;
         OP_AND:         return 5'b00100;
         OP_OR:          return 5'b01000;
         OP_XOR:         return 5'b10000;
         default:        return 5'b00000;
      endcase
   endfunction

   function automatic logic is_add(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_ADC);
   endfunction

   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SBB);
   endfunction

   assign cmd_ready = (state == IDLE) && !rst;
   assign q_arith   = is_add(op_q) || is_sub(op_q);
   assign q_illegal = (op_q == OP_ILL);
   assign res_zero  = wide_q ? (res == 16'd0) : (res[7:0] == 8'd0);

   // RESP spends one cycle formatting the response from res, then holds it until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         op_q         <= 3'd0;
         wide_q       <= 1'b0;
         a_hi         <= 8'd0;
         b_hi         <= 8'd0;
         res          <= 16'd0;
         c_int        <= 1'b0;
         v_int        <= 1'b0;
         c_flag       <= 1'b0;
         alu_a        <= 8'd0;
         alu_b        <= 8'd0;
         alu_cin      <= 1'b0;
         alu_bin      <= 1'b0;
         alu_sel      <= 5'd0;
         rsp_valid    <= 1'b0;
         rsp_z        <= 16'd0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  wide_q <= cmd_wide;
                  a_hi   <= cmd_a[15:8];
                  b_hi   <= cmd_b[15:8];
                  res    <= 16'd0;
                  c_int  <= 1'b0;
                  v_int  <= 1'b0;
                  if (cmd_op == OP_ILL) begin
                     state <= RESP;
                  end else begin
                     alu_a   <= cmd_a[7:0];
                     alu_b   <= cmd_b[7:0];
                     alu_sel <= sel_of(cmd_op);
                     alu_cin <= (cmd_op == OP_ADC) ? c_flag : 1'b0;
                     alu_bin <= (cmd_op == OP_SUB) ? 1'b1 :
                                (cmd_op == OP_SBB) ? c_flag : 1'b0;
                     state   <= LO;
                  end
               end
            end
            LO: begin
               res[7:0] <= alu_z;
               c_int    <= alu_carry;
               v_int    <= alu_overflow;
               if (wide_q) begin
                  alu_a   <= a_hi;
                  alu_b   <= b_hi;
                  alu_cin <= is_add(op_q) && alu_carry;
                  alu_bin <= is_sub(op_q) && alu_carry;
                  state   <= HI;
               end else begin
                  alu_a   <= 8'd0;
                  alu_b   <= 8'd0;
                  alu_cin <= 1'b0;
                  alu_bin <= 1'b0;
                  alu_sel <= 5'd0;
                  state   <= RESP;
               end
            end
            HI: begin
               res[15:8] <= alu_z;
               c_int     <= alu_carry;
               v_int     <= alu_overflow;
               alu_a     <= 8'd0;
               alu_b     <= 8'd0;
               alu_cin   <= 1'b0;
               alu_bin   <= 1'b0;
               alu_sel   <= 5'd0;
               state     <= RESP;
            end
            RESP: begin
               if (!rsp_valid) begin
                  rsp_valid    <= 1'b1;
                  rsp_z        <= q_illegal ? 16'd0 : (wide_q ? res : {8'd0, res[7:0]});
                  rsp_carry    <= q_arith && c_int;
                  rsp_overflow <= q_arith && v_int;
                  rsp_zero     <= !q_illegal && res_zero;
                  rsp_err      <= q_illegal;
                  if (q_arith) begin
                     c_flag <= c_int;
                  end
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural 8-bit stack, whole-word response model with
// a stored-carry scoreboard, and directed vectors with literal expectations.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic        cmd_wide;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_cin;
   logic        alu_bin;
   logic [4:0]  alu_sel;
   logic [7:0]  alu_z;
   logic        alu_carry;
   logic        alu_overflow;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_z;
   logic        rsp_carry;
   logic        rsp_overflow;
   logic        rsp_zero;
   logic        rsp_err;

   int n_tests    = 0;
   int n_fail     = 0;
   int cyc        = 0;
   int accept_cyc = 0;
   int lat        = 0;

   typedef struct packed {
      logic [15:0] z;
      logic        carry;
      logic        overflow;
      logic        zero;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   logic model_c = 1'b0;

   alu_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_wide     (cmd_wide),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_cin      (alu_cin),
      .alu_bin      (alu_bin),
      .alu_sel      (alu_sel),
      .alu_z        (alu_z),
      .alu_carry    (alu_carry),
      .alu_overflow (alu_overflow),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_z        (rsp_z),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .rsp_zero     (rsp_zero),
      .rsp_err      (rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Combinational byte stack; logic ops report junk flags so the sequencer must mask them.
   logic [8:0] stack_sum;
   logic [7:0] stack_nb;
   always_comb begin
      stack_nb     = ~alu_b;
      stack_sum    = 9'd0;
      alu_z        = 8'd0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (alu_sel)
         5'b00001: begin
            stack_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            alu_z        = stack_sum[7:0];
            alu_carry    = stack_sum[8];
            alu_overflow = (alu_a[7] == alu_b[7]) && (stack_sum[7] != alu_a[7]);
         end
         5'b00010: begin
            stack_sum    = {1'b0, alu_a} + {1'b0, stack_nb} + {8'd0, alu_bin};
            alu_z        = stack_sum[7:0];
            alu_carry    = stack_sum[8];
            alu_overflow = (alu_a[7] == stack_nb[7]) && (stack_sum[7] != alu_a[7]);
         end
         5'b00100: begin alu_z = alu_a & alu_b; alu_carry = 1'b1; alu_overflow = 1'b1; end
         5'b01000: begin alu_z = alu_a | alu_b; alu_carry = 1'b1; alu_overflow = 1'b1; end
         5'b10000: begin alu_z = alu_a ^ alu_b; alu_carry = 1'b1; alu_overflow = 1'b1; end
         default: ;
      endcase
   end

   function automatic logic op_is_arith(input logic [2:0] op);
      return (op == 3'd0) || (op == 3'd1) || (op == 3'd5) || (op == 3'd6);
   endfunction

   // Whole-operand arithmetic at the operation width; no byte slicing.
   function automatic rsp_t model_rsp(input logic [2:0] op, input logic wide,
                                      input logic [15:0] a, input logic [15:0] b, input logic c);
      rsp_t        r;
      int unsigned w;
      int unsigned mask;
      int unsigned x;
      int unsigned y;
      int unsigned cin;
      int unsigned s;
      bit          sa;
      bit          sb;
      bit          ss;
      r = '0;
      if (op == 3'd7) begin
         r.err = 1'b1;
         return r;
      end
      w    = wide ? 32'd16 : 32'd8;
      mask = (32'd1 << w) - 32'd1;
      x    = {16'd0, a} & mask;
      y    = {16'd0, b} & mask;
      cin  = 32'd0;
      if (op == 3'd1 || op == 3'd6) y = ~y & mask;
      if (op == 3'd1) cin = 32'd1;
      if (op == 3'd5 || op == 3'd6) cin = {31'd0, c};
      if (op_is_arith(op)) begin
         s          = x + y + cin;
         r.carry    = ((s >> w) & 32'd1) != 32'd0;
         s          = s & mask;
         sa         = ((x >> (w - 1)) & 32'd1) != 32'd0;
         sb         = ((y >> (w - 1)) & 32'd1) != 32'd0;
         ss         = ((s >> (w - 1)) & 32'd1) != 32'd0;
         r.overflow = (sa == sb) && (ss != sa);
      end else if (op == 3'd2) begin
         s = x & y;
      end else if (op == 3'd3) begin
         s = x | y;
      end else begin
         s = x ^ y;
      end
      r.z    = s[15:0];
      r.zero = (s == 32'd0);
      return r;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expectations pushed on accept, popped on retirement, cleared by reset.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_c <= 1'b0;
      end else begin
         if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back(model_rsp(cmd_op, cmd_wide, cmd_a, cmd_b, model_c));
            if (op_is_arith(cmd_op)) model_c <= exp_q[$].carry;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0)
            check_output("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
         else
            check_output("rsp_model", {12'd0, rsp_z, rsp_carry, rsp_overflow, rsp_zero, rsp_err},
                         {12'd0, exp_q[0]});
      end
   end

   task automatic apply_stimulus(input logic [2:0] op, input logic wide,
                                 input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_wide  = wide;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check_output("accept_timeout", {31'd0, cmd_ready}, 32'd1);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         accept_cyc = cyc;
         cmd_valid  = 1'b0;
      end
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_output("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
      lat = cyc - accept_cyc;
   endtask

   task automatic check_rsp(input string tag, input int exp_lat, input logic [15:0] z,
                            input logic c, input logic v, input logic zf, input logic err);
      check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_output({tag, "_z"}, {16'd0, rsp_z}, {16'd0, z});
      check_output({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, c});
      check_output({tag, "_overflow"}, {31'd0, rsp_overflow}, {31'd0, v});
      check_output({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, zf});
      check_output({tag, "_err"}, {31'd0, rsp_err}, {31'd0, err});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_wide  = 1'b0;
      cmd_a     = 16'd0;
      cmd_b     = 16'd0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_output("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check_output("reset_alu_sel", {27'd0, alu_sel}, 32'd0);
      check_output("reset_alu_a", {24'd0, alu_a}, 32'd0);
      check_output("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_output("reset_rsp_z", {16'd0, rsp_z}, 32'd0);
      rst = 1'b0;
      #1;
      check_output("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      apply_stimulus(3'd0, 1'b0, 16'h007F, 16'h0001);
      check_output("add8_alu_sel", {27'd0, alu_sel}, 32'h01);
      check_output("add8_alu_a", {24'd0, alu_a}, 32'h7F);
      wait_rsp();
      check_rsp("add8", 2, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0);

      apply_stimulus(3'd0, 1'b1, 16'h00FF, 16'h0001);
      @(negedge clk);
      check_output("add16_lo_alu_a", {24'd0, alu_a}, 32'hFF);
      @(negedge clk);
      check_output("add16_hi_alu_cin", {31'd0, alu_cin}, 32'd1);
      check_output("add16_hi_alu_a", {24'd0, alu_a}, 32'h00);
      wait_rsp();
      check_rsp("add16", 3, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

      apply_stimulus(3'd0, 1'b1, 16'hFFFF, 16'h0001);
      wait_rsp();
      check_rsp("add16_wrap", 3, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

      apply_stimulus(3'd5, 1'b0, 16'h0000, 16'h0000);
      wait_rsp();
      check_rsp("adc8", 2, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);

      apply_stimulus(3'd1, 1'b0, 16'h0005, 16'h0006);
      wait_rsp();
      check_rsp("sub8", 2, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);

      apply_stimulus(3'd6, 1'b0, 16'h0010, 16'h0000);
      wait_rsp();
      check_rsp("sbb8", 2, 16'h000F, 1'b1, 1'b0, 1'b0, 1'b0);

      apply_stimulus(3'd2, 1'b1, 16'hF0F0, 16'h3C3C);
      @(negedge clk);
      check_output("and16_lo_sel", {27'd0, alu_sel}, 32'h04);
      @(negedge clk);
      check_output("and16_hi_sel", {27'd0, alu_sel}, 32'h04);
      wait_rsp();
      check_rsp("and16", 3, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0);

      // Stored carry is still 1 from the SBB; the AND must not have touched it.
      apply_stimulus(3'd5, 1'b0, 16'h0001, 16'h0001);
      wait_rsp();
      check_rsp("adc_after_logic", 2, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);

      apply_stimulus(3'd3, 1'b0, 16'hAB12, 16'hCD21);
      wait_rsp();
      check_rsp("or8", 2, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b0);

      apply_stimulus(3'd4, 1'b1, 16'hFFFF, 16'hFFFF);
      wait_rsp();
      check_rsp("xor16", 3, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

      apply_stimulus(3'd7, 1'b1, 16'h1234, 16'h5678);
      @(negedge clk);
      check_output("ill_alu_sel", {27'd0, alu_sel}, 32'd0);
      wait_rsp();
      check_rsp("illegal", 1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      rsp_ready = 1'b0;
      apply_stimulus(3'd1, 1'b1, 16'h1000, 16'h0001);
      wait_rsp();
      check_rsp("sub16_bp", 3, 16'h0FFF, 1'b1, 1'b0, 1'b0, 1'b0);
      cmd_op    = 3'd0;
      cmd_wide  = 1'b0;
      cmd_a     = 16'h0040;
      cmd_b     = 16'h0040;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_output("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         check_output("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check_output("bp_rsp_z", {16'd0, rsp_z}, 32'h0FFF);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check_output("retire_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_output("retire_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      cmd_valid  = 1'b0;
      check_output("pending_accepted", {31'd0, cmd_ready}, 32'd0);
      wait_rsp();
      check_rsp("pending_add8", 2, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0);

      apply_stimulus(3'd0, 1'b0, 16'h00FF, 16'h0001);
      wait_rsp();
      check_rsp("set_carry", 2, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(3'd0, 1'b1, 16'h1234, 16'h1111);
      @(negedge clk);
      @(negedge clk);
      check_output("rst_hi_alu_a", {24'd0, alu_a}, 32'h12);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_output("rst_alu_sel", {27'd0, alu_sel}, 32'd0);
      check_output("rst_alu_a", {24'd0, alu_a}, 32'd0);
      check_output("rst_alu_b", {24'd0, alu_b}, 32'd0);
      check_output("rst_alu_cin", {31'd0, alu_cin}, 32'd0);
      check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_output("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      repeat (4) begin
         @(negedge clk);
         check_output("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      apply_stimulus(3'd5, 1'b0, 16'h0000, 16'h0000);
      wait_rsp();
      check_rsp("adc_after_rst", 2, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
